pwm_fade_ctrl: RTL and testbench

Sits between the I2C slave's register bus (addr/wr_en/rd_en/wdata) and pwm_register. It forwards host accesses unchanged and arbitrates them against an internal ramp engine. The engine steps duty1/duty2 toward programmed targets, one step per N PWM period wraps, writing through the same register bus. It provides soft-start and fades without host traffic per step.

---
 rtl/pwm_fade_pkg.sv | 36 +++
 rtl/pwm_fade_step.sv | 18 +
 rtl/pwm_fade_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pwm_fade_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared types and helpers for the PWM fade controller: FSM states, default
// duty register offsets and the saturating step function.
package pwm_fade_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_CALC = 3'd2,
    ST_WR1  = 3'd3,
    ST_WR2  = 3'd4,
    ST_DONE = 3'd5
  } fade_state_e;

  localparam logic [3:0] DUTY1_ADDR_DEF = 4'h2;
  localparam logic [3:0] DUTY2_ADDR_DEF = 4'h3;

  // Wide enough that any channel width up to 64 can be zero-extended in.
  localparam int SAT_W = 64;

  // Move cur one step toward tgt without overshooting it; the extra sum bit
  // keeps an up-step near the top of the range from wrapping.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] cur,
                                                input logic [SAT_W-1:0] tgt,
                                                input logic [SAT_W-1:0] step);
    logic [SAT_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (cur < tgt) begin
      sat_step = (sum > {1'b0, tgt}) ? tgt : sum[SAT_W-1:0];
    end else if (cur > tgt) begin
      sat_step = ((cur - tgt) <= step) ? tgt : (cur - step);
    end else begin
      sat_step = cur;
    end
  endfunction

endpackage

// File: rtl/pwm_fade_step.sv
// One channel of the ramp engine: combinational saturating step from the
// current shadow value toward the target, plus a changed flag.
module pwm_fade_step
  import pwm_fade_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] next_o,
  output logic             chg_o
);

  assign next_o = WIDTH'(sat_step(SAT_W'(cur_i), SAT_W'(tgt_i), SAT_W'(step_i)));
  assign chg_o  = (next_o != cur_i);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Register-bus arbiter plus ramp engine: forwards host accesses untouched and
// slips engine writes to duty1/duty2 into idle bus cycles, one step per interval.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         IVL_W      = 16,
  parameter logic [3:0] DUTY1_ADDR = DUTY1_ADDR_DEF,
  parameter logic [3:0] DUTY2_ADDR = DUTY2_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       h_addr,
  input  logic              h_wr_en,
  input  logic              h_rd_en,
  input  logic [31:0]       h_wdata,
  output logic [15:0]       r_addr,
  output logic              r_wr_en,
  output logic              r_rd_en,
  output logic [31:0]       r_wdata,
  input  logic              cnt_wrap,
  input  logic [WIDTH-1:0]  cur_duty1,
  input  logic [WIDTH-1:0]  cur_duty2,
  input  logic              ramp_start,
  input  logic              ramp_abort,
  input  logic [WIDTH-1:0]  tgt1,
  input  logic [WIDTH-1:0]  tgt2,
  input  logic [WIDTH-1:0]  step,
  input  logic [IVL_W-1:0]  interval,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output fade_state_e       dbg_state_o
);

  fade_state_e      state_q;
  logic [WIDTH-1:0] sh1_q, sh2_q, tgt1_q, tgt2_q, step_q;
  logic [IVL_W-1:0] ivl_q, ivl_cnt_q;
  logic             chg1_q, chg2_q;
  logic             busy_q, done_q, aborted_q;

  logic [WIDTH-1:0] nxt1_d, nxt2_d;
  logic             chg1_d, chg2_d;
  logic [IVL_W:0]   ivl_inc;
  logic             wrap_hit;
  logic             host_act, host_duty_wr, abort_req;
  logic             eng_wr1, eng_wr2, eng_wr;

  pwm_fade_step #(.WIDTH(WIDTH)) u_step1 (
    .cur_i (sh1_q),
    .tgt_i (tgt1_q),
    .step_i(step_q),
    .next_o(nxt1_d),
    .chg_o (chg1_d)
  );

  pwm_fade_step #(.WIDTH(WIDTH)) u_step2 (
    .cur_i (sh2_q),
    .tgt_i (tgt2_q),
    .step_i(step_q),
    .next_o(nxt2_d),
    .chg_o (chg2_d)
  );

  assign host_act     = h_wr_en | h_rd_en;
  assign host_duty_wr = h_wr_en & ((h_addr[3:0] == DUTY1_ADDR) | (h_addr[3:0] == DUTY2_ADDR));
  assign abort_req    = ramp_abort | (host_duty_wr & busy_q);

  assign ivl_inc  = {1'b0, ivl_cnt_q} + {{IVL_W{1'b0}}, 1'b1};
  assign wrap_hit = (ivl_inc == {1'b0, ivl_q});

  // An engine write needs a free bus and must not land in an abort cycle.
  assign eng_wr1 = (state_q == ST_WR1) & chg1_q;
  assign eng_wr2 = (state_q == ST_WR2) & chg2_q;
  assign eng_wr  = (eng_wr1 | eng_wr2) & ~host_act & ~abort_req;

  always_comb begin
    r_addr  = '0;
    r_wdata = '0;
    r_wr_en = 1'b0;
    if (host_act) begin
      r_addr  = h_addr;
      r_wdata = h_wdata;
      r_wr_en = h_wr_en;
    end else if (eng_wr) begin
      r_wr_en = 1'b1;
      r_addr  = eng_wr1 ? 16'(DUTY1_ADDR) : 16'(DUTY2_ADDR);
      r_wdata = eng_wr1 ? 32'(sh1_q) : 32'(sh2_q);
    end
  end

  assign r_rd_en     = h_rd_en;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sh1_q     <= '0;
      sh2_q     <= '0;
      tgt1_q    <= '0;
      tgt2_q    <= '0;
      step_q    <= '0;
      ivl_q     <= '0;
      ivl_cnt_q <= '0;
      chg1_q    <= 1'b0;
      chg2_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort_req) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
        ivl_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ramp_start) begin
              sh1_q     <= cur_duty1;
              sh2_q     <= cur_duty2;
              tgt1_q    <= tgt1;
              tgt2_q    <= tgt2;
              step_q    <= (step == '0) ? WIDTH'(1) : step;
              ivl_q     <= (interval == '0) ? IVL_W'(1) : interval;
              ivl_cnt_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (cnt_wrap) begin
              if (wrap_hit) begin
                ivl_cnt_q <= '0;
                state_q   <= ST_CALC;
              end else begin
                ivl_cnt_q <= ivl_inc[IVL_W-1:0];
              end
            end
          end
          ST_CALC: begin
            sh1_q   <= nxt1_d;
            sh2_q   <= nxt2_d;
            chg1_q  <= chg1_d;
            chg2_q  <= chg2_d;
            state_q <= ST_WR1;
          end
          ST_WR1: begin
            if (!chg1_q || !host_act) state_q <= ST_WR2;
          end
          ST_WR2: begin
            if (!chg2_q || !host_act) begin
              if ((sh1_q == tgt1_q) && (sh2_q == tgt2_q)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_WAIT;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: a small duty register model, ramp vectors with the
// expected engine writes (wrap index, address, data) queued per ramp.
module tb_pwm_fade_ctrl;
  import pwm_fade_pkg::*;

  localparam logic [3:0] A1 = 4'h2;
  localparam logic [3:0] A2 = 4'h3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] h_addr = '0;
  logic        h_wr_en = 1'b0, h_rd_en = 1'b0;
  logic [31:0] h_wdata = '0;
  logic [15:0] r_addr;
  logic        r_wr_en, r_rd_en;
  logic [31:0] r_wdata;
  logic        cnt_wrap = 1'b0;
  logic [31:0] reg1, reg2;
  logic        ramp_start = 1'b0, ramp_abort = 1'b0;
  logic [31:0] tgt1 = '0, tgt2 = '0, step = '0;
  logic [15:0] interval = '0;
  logic        busy, done, aborted;
  fade_state_e dbg_state;

  logic        preset_en = 1'b0;
  logic [31:0] preset1 = '0, preset2 = '0;

  int checks = 0, failures = 0;
  int wraps_seen = 0, done_cnt = 0, abort_cnt = 0;
  logic [43:0] exp_q[$];

  typedef struct {
    logic [31:0]       c1, t1, c2, t2, stp;
    logic [15:0]       ivl;
    int                nw;
    logic [5:0][43:0]  wr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pwm_fade_ctrl dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_wr_en(h_wr_en), .h_rd_en(h_rd_en), .h_wdata(h_wdata),
    .r_addr(r_addr), .r_wr_en(r_wr_en), .r_rd_en(r_rd_en), .r_wdata(r_wdata),
    .cnt_wrap(cnt_wrap), .cur_duty1(reg1), .cur_duty2(reg2),
    .ramp_start(ramp_start), .ramp_abort(ramp_abort),
    .tgt1(tgt1), .tgt2(tgt2), .step(step), .interval(interval),
    .busy(busy), .done(done), .aborted(aborted), .dbg_state_o(dbg_state)
  );

  // Stand-in for pwm_register: only the two duty registers matter here.
  always @(posedge clk) begin
    if (preset_en) begin
      reg1 <= preset1;
      reg2 <= preset2;
    end else if (r_wr_en) begin
      if (r_addr == 16'(A1)) reg1 <= r_wdata;
      if (r_addr == 16'(A2)) reg2 <= r_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every engine-driven write is popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (r_wr_en && !(h_wr_en || h_rd_en)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_engine_wr actual=%h/%h expected=none", r_addr, r_wdata);
        end else begin
          logic [43:0] e;
          e = exp_q.pop_front();
          chk("engine_wr", {8'(wraps_seen), r_addr, r_wdata}, {8'h0, e[43:36], 12'h0, e[35:0]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (cnt_wrap) wraps_seen++;
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] c1, t1, c2, t2, stp, input logic [15:0] ivl);
    vec_t v;
    v.c1 = c1; v.t1 = t1; v.c2 = c2; v.t2 = t2; v.stp = stp; v.ivl = ivl;
    v.nw = 0;
    v.wr = '0;
    return v;
  endfunction

  function automatic vec_t pw(input vec_t v, input int wrap, input logic [3:0] a, input logic [31:0] d);
    v.wr[v.nw] = {8'(wrap), a, d};
    v.nw++;
    return v;
  endfunction

  task automatic preset(input logic [31:0] p1, input logic [31:0] p2);
    preset1 = p1; preset2 = p2; preset_en = 1'b1;
    tick();
    preset_en = 1'b0;
  endtask

  task automatic start_ramp(input logic [31:0] t1v, t2v, sv, input logic [15:0] iv);
    tgt1 = t1v; tgt2 = t2v; step = sv; interval = iv;
    wraps_seen = 0;
    ramp_start = 1'b1;
    tick();
    ramp_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < budget; c++) begin
      cnt_wrap = (c % 4 == 0);
      tick();
      if (done_cnt != d0) break;
    end
    cnt_wrap = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int d0, a0;
    preset(v.c1, v.c2);
    for (int i = 0; i < v.nw; i++) exp_q.push_back(v.wr[i]);
    d0 = done_cnt; a0 = abort_cnt;
    start_ramp(v.t1, v.t2, v.stp, v.ivl);
    @(negedge clk);
    chk($sformatf("v%0d_busy_after_start", id), 64'(busy), 64'd1);
    wait_done(800);
    chk($sformatf("v%0d_done_once", id), 64'(done_cnt - d0), 64'd1);
    chk($sformatf("v%0d_no_abort", id), 64'(abort_cnt - a0), 64'd0);
    chk($sformatf("v%0d_busy_low", id), 64'(busy), 64'd0);
    chk($sformatf("v%0d_writes_left", id), 64'(exp_q.size()), 64'd0);
    chk($sformatf("v%0d_duty1", id), 64'(reg1), 64'(v.t1));
    chk($sformatf("v%0d_duty2", id), 64'(reg2), 64'(v.t2));
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    int d0, a0;

    // Up-ramp with saturation at the last step; channel 2 already at target.
    v = mk(0, 100, 50, 50, 30, 1);
    v = pw(v, 1, A1, 30); v = pw(v, 2, A1, 60); v = pw(v, 3, A1, 90); v = pw(v, 4, A1, 100);
    vecs.push_back(v);
    // Down-ramp clamps at 0 after the second wrap.
    v = mk(5, 5, 10, 0, 25, 2);
    v = pw(v, 2, A2, 0);
    vecs.push_back(v);
    // step=0 and interval=0 both behave as 1.
    v = mk(0, 3, 7, 7, 0, 0);
    v = pw(v, 1, A1, 1); v = pw(v, 2, A1, 2); v = pw(v, 3, A1, 3);
    vecs.push_back(v);
    // Both channels moving in opposite directions.
    v = mk(200, 0, 0, 150, 100, 1);
    v = pw(v, 1, A1, 100); v = pw(v, 1, A2, 100); v = pw(v, 2, A1, 0); v = pw(v, 2, A2, 150);
    vecs.push_back(v);
    // Already at target: one silent pass, then done.
    v = mk(9, 9, 4, 4, 1, 3);
    vecs.push_back(v);
    // Up-step near the top of the range must not wrap.
    v = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1);
    v = pw(v, 1, A1, 32'hFFFF_FFFF);
    vecs.push_back(v);
    // Interval of 3 wraps per step.
    v = mk(50, 20, 1, 1, 10, 3);
    v = pw(v, 3, A1, 40); v = pw(v, 6, A1, 30); v = pw(v, 9, A1, 20);
    vecs.push_back(v);

    tick(); tick();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_bus", {15'h0, r_wr_en, r_addr, r_wdata}, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Host write holds the bus in the cycle the engine write is due.
    preset(0, 0);
    exp_q.push_back({8'd1, A1, 32'd10});
    start_ramp(10, 0, 10, 1);
    cnt_wrap = 1'b1; tick(); cnt_wrap = 1'b0; tick();
    h_wr_en = 1'b1; h_addr = 16'h0; h_wdata = 32'hAA;
    @(negedge clk);
    chk("contention_host_fwd", {31'h0, r_wr_en, r_addr, r_wdata[15:0]}, {31'h0, 1'b1, 16'h0, 16'hAA});
    tick();
    h_wr_en = 1'b0; h_wdata = '0;
    @(negedge clk);
    chk("contention_engine_late", {31'h0, r_wr_en, r_addr, r_wdata[15:0]}, {31'h0, 1'b1, 16'h2, 16'd10});
    d0 = done_cnt;
    wait_done(40);
    chk("contention_done", 64'(done_cnt - d0), 64'd1);
    chk("contention_writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Host write to duty1 mid-ramp aborts the engine.
    preset(0, 0);
    exp_q.push_back({8'd1, A1, 32'd10});
    d0 = done_cnt; a0 = abort_cnt;
    start_ramp(100, 0, 10, 1);
    cnt_wrap = 1'b1; tick(); cnt_wrap = 1'b0; tick(); tick(); tick();
    h_wr_en = 1'b1; h_addr = 16'h2; h_wdata = 32'd7;
    @(negedge clk);
    chk("override_fwd", {31'h0, r_wr_en, r_addr, r_wdata[15:0]}, {31'h0, 1'b1, 16'h2, 16'd7});
    tick();
    h_wr_en = 1'b0; h_addr = '0; h_wdata = '0;
    @(negedge clk);
    chk("override_aborted_busy", {aborted, busy}, 2'b10);
    for (int c = 0; c < 20; c++) begin
      cnt_wrap = (c % 4 == 0);
      tick();
    end
    cnt_wrap = 1'b0;
    chk("override_abort_once", 64'(abort_cnt - a0), 64'd1);
    chk("override_no_done", 64'(done_cnt - d0), 64'd0);
    chk("override_writes_left", 64'(exp_q.size()), 64'd0);
    chk("override_duty1", 64'(reg1), 64'd7);
    exp_q.delete();

    // ramp_abort right after start: no writes at all.
    start_ramp(100, 0, 10, 1);
    ramp_abort = 1'b1; tick(); ramp_abort = 1'b0;
    @(negedge clk);
    chk("ramp_abort_pulse", {aborted, busy}, 2'b10);
    for (int c = 0; c < 12; c++) begin
      cnt_wrap = (c % 4 == 0);
      tick();
    end
    cnt_wrap = 1'b0;
    chk("ramp_abort_state", 64'(dbg_state), 64'(ST_IDLE));

    // Reset between the duty1 and duty2 writes of a step.
    preset(0, 0);
    exp_q.push_back({8'd1, A1, 32'd10});
    start_ramp(100, 100, 10, 1);
    cnt_wrap = 1'b1; tick(); cnt_wrap = 1'b0; tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_wr", {busy, r_wr_en}, 2'b00);
    chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midrst_writes_left", 64'(exp_q.size()), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    v = mk(10, 20, 0, 0, 10, 1);
    v = pw(v, 1, A1, 20);
    run_vec(v, 99);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
